veda_mc_ctrl: RTL

VEDA_MC_CTRL -- requirements
Module: veda_mc_ctrl

---
 rtl/veda_mc_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/veda_mc_ctrl.sv
// veda_mc_ctrl: multi-cycle fetch/decode/execute controller for a small MIPS-like instruction set.
module veda_mc_ctrl #(
  parameter int IMEM_AW = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ins_data,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        dmem_mode,
  output logic        rf_we,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE, ERR} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, ir_n, imm_sext;
  logic [15:0] cnt_n, cnt_inc;
  logic [5:0] opcode, funct;
  logic is_r, is_addi, is_lw, is_sw, is_bne, is_halt, r_ok, legal, pc_oob;
  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign is_r     = opcode == 6'b000000;
  assign is_addi  = opcode == 6'b000011;
  assign is_lw    = opcode == 6'b001000;
  assign is_sw    = opcode == 6'b001001;
  assign is_bne   = opcode == 6'b001011;
  assign is_halt  = opcode == 6'b111111;
  assign r_ok     = funct inside {6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001000};
  assign legal    = (is_r && r_ok) || is_addi || is_lw || is_sw || is_bne;
  assign pc_oob   = (pc >> IMEM_AW) != 32'd0;
  assign cnt_inc  = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
  assign busy     = state inside {FETCH, DECODE, EXEC, MEM, WB};
  assign done     = state == DONE;
  assign err      = state == ERR;
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    cnt_n       = instr_count;
    alu_op      = 3'b000;
    alu_src_imm = 1'b0;
    dmem_mode   = 1'b1;
    rf_we       = 1'b0;
    mem_to_reg  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = FETCH;
        pc_n    = 32'd0;
        cnt_n   = 16'd0;
      end
      FETCH: if (pc_oob) state_n = ERR;
             else begin
               ir_n    = ins_data;
               state_n = DECODE;
             end
      DECODE: state_n = is_halt ? DONE : legal ? EXEC : ERR;
      EXEC: begin
        alu_op      = is_r ? ((funct == 6'b001000) ? 3'b100 : funct[2:0]) : is_bne ? 3'b001 : 3'b000;
        alu_src_imm = is_addi || is_lw || is_sw;
        state_n     = is_bne ? FETCH : (is_lw || is_sw) ? MEM : WB;
        if (is_bne) begin
          pc_n  = pc + (alu_zero ? 32'd1 : imm_sext);
          cnt_n = cnt_inc;
        end
      end
      MEM: begin
        dmem_mode = !is_sw;
        state_n   = is_sw ? FETCH : WB;
        if (is_sw) begin
          pc_n  = pc + 32'd1;
          cnt_n = cnt_inc;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        mem_to_reg = is_lw;
        state_n    = FETCH;
        pc_n       = pc + 32'd1;
        cnt_n      = cnt_inc;
      end
      default: state_n = ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= 32'd0;
      ir          <= 32'd0;
      instr_count <= 16'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir          <= ir_n;
      instr_count <= cnt_n;
    end
  end
endmodule
